// File: rtl/udma_i2s_pkg.sv
// Shared I2S/uDMA definitions: packing modes and per-mode lane geometry.
package udma_i2s_pkg;

    localparam int unsigned WordW = 32;

    typedef enum logic [1:0] {
        PackW32  = 2'd0,
        PackH16  = 2'd1,
        PackB8   = 2'd2,
        PackRsvd = 2'd3
    } pack_mode_e;

    // Lanes per output word; the reserved encoding behaves as 1x32.
    function automatic logic [2:0] lane_count(input logic [1:0] mode);
        case (pack_mode_e'(mode))
            PackH16: return 3'd2;
            PackB8:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Lane width in bits (WordW / lane_count).
    function automatic logic [5:0] lane_width(input logic [1:0] mode);
        case (pack_mode_e'(mode))
            PackH16: return 6'd16;
            PackB8:  return 6'd8;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/i2s_rx_packer_if.sv
// Sample-in / word-out stream bundle for the I2S RX packer.
// Signal suffixes are relative to the packer (slave side).
interface i2s_rx_packer_if;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        err_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, err_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, err_o
    );
endinterface

// File: rtl/i2s_rx_packer.sv
// Packs 1, 2 or 4 left-justified audio samples into 32-bit words.
// Samples fill lanes from the LSB upward; a completed word sits in a single
// output register until the consumer takes it.
module i2s_rx_packer
    import udma_i2s_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_en_i,
    input  logic [4:0]        cfg_wlen_i,
    input  logic [1:0]        cfg_mode_i,
    i2s_rx_packer_if.slave    bus
);

    // Left-justify the sample at bit 31, then keep only its top lw bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] data,
                                                 input logic [4:0]  wlen,
                                                 input logic [5:0]  lw);
        logic [31:0] shl;
        shl = data << (5'd31 - wlen);
        return shl >> (6'd32 - lw);
    endfunction

    logic [31:0] acc_q;
    logic [1:0]  cnt_q;
    logic [31:0] data_q;
    logic        valid_q;

    logic [2:0]  lanes_n;
    logic [5:0]  lane_w;
    logic [5:0]  lane_shift;
    logic        last_lane;
    logic [31:0] placed;
    logic        ready;
    logic        in_xfer;
    logic        out_xfer;

    // Lane geometry, handshakes and the shifted lane for the current sample.
    always_comb begin
        lanes_n    = lane_count(cfg_mode_i);
        lane_w     = lane_width(cfg_mode_i);
        last_lane  = (cnt_q == 2'(lanes_n - 3'd1));
        lane_shift = {4'd0, cnt_q} * lane_w;
        placed     = lane_extract(bus.data_i, cfg_wlen_i, lane_w) << lane_shift;
        // A completing sample may enter only if the output slot frees this cycle.
        ready      = cfg_en_i & (~last_lane | ~valid_q | bus.ready_i);
        in_xfer    = bus.valid_i & ready;
        out_xfer   = valid_q & bus.ready_i;
    end

    assign bus.ready_o = ready;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = cfg_en_i & bus.valid_i & ~ready;

    // Accumulator, lane counter and output register; reset wins over transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (out_xfer) begin
                valid_q <= 1'b0;
            end
            if (!cfg_en_i) begin
                // Disabling discards any partial word; a finished word still drains.
                acc_q <= '0;
                cnt_q <= '0;
            end else if (in_xfer) begin
                if (last_lane) begin
                    data_q  <= acc_q | placed;
                    valid_q <= 1'b1;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end else begin
                    acc_q <= acc_q | placed;
                    cnt_q <= cnt_q + 2'd1;
                end
            end
        end
    end

endmodule
